muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 clk  input  1  rising-edge clock; the block's only clock.
REQ-002 rst_n  input  1  reset, asynchronous assertion, active-low.
REQ-003 start  input  1  operation request, qualified by alu_ctrl.
REQ-004 alu_ctrl  input  6  ALU control code (bits [4:0] used; bit 5 ignored): 01000 mult, 01010 div, 01111 mfhi, 00001 mflo.
REQ-005 a  input  32  operand rs; multiplicand or dividend.
REQ-006 b  input  32  operand rt; multiplier or divisor.
REQ-007 busy  output  1  iterative mult/div in progress; upstream stalls.
REQ-008 done  output  1  one-cycle pulse; HI/LO updated this cycle.
REQ-009 hi  output  32  HI register.
REQ-010 lo  output  32  LO register.
REQ-011 result  output  32  registered mfhi/mflo read data.
REQ-012 div_by_zero  output  1  one-cycle pulse with done when divisor was 0.

Function
REQ-013 States: IDLE, MUL, DIV, FIX. busy=1 in MUL, DIV and FIX.
REQ-014 Accept: start=1 in IDLE with mult/div code; a and b are latched at that edge.
REQ-015 start while busy, or start with any other code: ignored; no state, HI/LO or result change.
REQ-016 MUL: shift-add, 1 multiplier bit per cycle, 32 cycles, then FIX.
REQ-017 DIV: restoring division, 1 quotient bit per cycle, 32 cycles, then FIX.
REQ-018 FIX, 1 cycle: apply signs; write HI/LO; done=1; next state IDLE. busy=1 for exactly 33 cycles after the accept edge.
REQ-019 mult: {HI,LO} = full 64-bit product.
REQ-020 div: LO = quotient, truncated toward zero; HI = remainder, sign of the dividend.
REQ-021 div, b=0: no iteration; FIX next cycle; HI=a, LO=0xFFFFFFFF; div_by_zero=1 with done; busy high for 1 cycle.
REQ-022 Signed div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0; no flag.
REQ-023 mfhi/mflo accepted in IDLE: result<=HI or LO at the next edge; no busy.
REQ-024 Otherwise result holds its value.
REQ-025 Back-to-back: a new start is accepted in the cycle after done.
REQ-026 Internal operands: 33-bit magnitudes; no overflow or truncation of intermediates.

Reset
REQ-027 rst_n=0 asynchronously forces IDLE; busy, done and div_by_zero go to 0; hi, lo and result go to 0x00000000.
REQ-028 Reset during MUL, DIV or FIX aborts the operation; HI/LO do not keep a partial result.
REQ-029 After rst_n rises, the first clock edge can accept a start.

Configuration
REQ-030 Macro MULDIV_SIGNED_EN:
- Defined: operands are two's complement; magnitudes are iterated and the signs are fixed in FIX (MIPS mult/div).
- Undefined: operands are unsigned (multu/divu semantics); FIX only writes HI/LO; the latency is unchanged.

Verification
REQ-031 Signed: mult, a=0xFFFFFFFD, b=7 -> busy 33 cycles, done pulse, HI=0xFFFFFFFF, LO=0xFFFFFFEB; then mflo -> result=0xFFFFFFEB.
REQ-032 Signed: div, a=0xFFFFFFEF (-17), b=5 -> LO=0xFFFFFFFD, HI=0xFFFFFFFE. Unsigned build: a=17, b=5 -> LO=3, HI=2.
REQ-033 div, a=0x12345678, b=0 -> busy 1 cycle; done and div_by_zero together; HI=0x12345678, LO=0xFFFFFFFF.
REQ-034 mult accepted, then a second start (div, mfhi) during busy -> ignored; HI/LO hold the mult product only; result unchanged.
REQ-035 rst_n low 10 cycles after a mult accept -> busy=0, HI=LO=result=0 immediately with no clock; no done pulse.
REQ-036 Unsigned build: mult, a=b=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001; next-cycle start is accepted.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative 32x32 multiply / divide unit with HI/LO registers and mfhi/mflo readback.
// Define MULDIV_SIGNED_EN for two's-complement operands (mult/div); otherwise multu/divu.
module muldiv_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [5:0]  alu_ctrl,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] result,
    output logic        div_by_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        FIX  = 2'd3
    } state_t;

    localparam logic [4:0] OP_MULT = 5'b01000;
    localparam logic [4:0] OP_DIV  = 5'b01010;
    localparam logic [4:0] OP_MFHI = 5'b01111;
    localparam logic [4:0] OP_MFLO = 5'b00001;

    state_t      state_reg;
    logic [4:0]  cnt_reg;
    logic [31:0] opb_reg;
    logic [63:0] prod_reg;
    logic [32:0] rem_reg;
    logic [31:0] quo_reg;
    logic        neg_lo_reg;
    logic        neg_hi_reg;
    logic        is_div_reg;
    logic        dbz_reg;
    logic        busy_reg;
    logic        done_reg;
    logic        dbz_out_reg;
    logic [31:0] hi_reg;
    logic [31:0] lo_reg;
    logic [31:0] result_reg;

    logic [4:0]  op;
    logic        sign_a;
    logic        sign_b;
    logic [32:0] mag_a;
    logic [32:0] mag_b;

    assign op = alu_ctrl[4:0];

`ifdef MULDIV_SIGNED_EN
    assign sign_a = a[31];
    assign sign_b = b[31];
`else
    assign sign_a = 1'b0;
    assign sign_b = 1'b0;
`endif

    // 33-bit magnitudes so that |-2^31| is representable without wrap.
    assign mag_a = sign_a ? (33'd0 - {1'b1, a}) : {1'b0, a};
    assign mag_b = sign_b ? (33'd0 - {1'b1, b}) : {1'b0, b};

    // Shift-add step: conditionally add the multiplicand to the upper half, then shift right.
    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    assign mul_sum  = {1'b0, prod_reg[63:32]} + (prod_reg[0] ? {1'b0, opb_reg} : 33'd0);
    assign mul_next = {mul_sum, prod_reg[31:1]};

    // Restoring step: shift the next dividend bit in, keep the difference if it did not go negative.
    logic [32:0] div_shift;
    logic [33:0] div_diff;
    logic        div_ok;
    assign div_shift = {rem_reg[31:0], quo_reg[31]};
    assign div_diff  = {1'b0, div_shift} - {2'b00, opb_reg};
    assign div_ok    = ~div_diff[33];

    logic [31:0] fix_hi;
    logic [31:0] fix_lo;
    always_comb begin
        fix_hi = 32'd0;
        fix_lo = 32'd0;
        if (is_div_reg) begin
            fix_lo = neg_lo_reg ? (32'd0 - quo_reg) : quo_reg;
            fix_hi = neg_hi_reg ? (32'd0 - rem_reg[31:0]) : rem_reg[31:0];
        end else begin
            {fix_hi, fix_lo} = neg_lo_reg ? (64'd0 - prod_reg) : prod_reg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            cnt_reg     <= 5'd0;
            opb_reg     <= 32'd0;
            prod_reg    <= 64'd0;
            rem_reg     <= 33'd0;
            quo_reg     <= 32'd0;
            neg_lo_reg  <= 1'b0;
            neg_hi_reg  <= 1'b0;
            is_div_reg  <= 1'b0;
            dbz_reg     <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            dbz_out_reg <= 1'b0;
            hi_reg      <= 32'd0;
            lo_reg      <= 32'd0;
            result_reg  <= 32'd0;
        end else begin
            done_reg    <= 1'b0;
            dbz_out_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        case (op)
                            OP_MULT: begin
                                state_reg  <= MUL;
                                busy_reg   <= 1'b1;
                                cnt_reg    <= 5'd31;
                                opb_reg    <= mag_a[31:0];
                                prod_reg   <= {32'd0, mag_b[31:0]};
                                neg_lo_reg <= sign_a ^ sign_b;
                                neg_hi_reg <= sign_a ^ sign_b;
                                is_div_reg <= 1'b0;
                                dbz_reg    <= 1'b0;
                            end
                            OP_DIV: begin
                                busy_reg   <= 1'b1;
                                is_div_reg <= 1'b1;
                                if (b == 32'd0) begin
                                    // Preload so FIX emits HI=a, LO=all-ones unchanged.
                                    state_reg  <= FIX;
                                    rem_reg    <= {1'b0, a};
                                    quo_reg    <= 32'hFFFF_FFFF;
                                    neg_lo_reg <= 1'b0;
                                    neg_hi_reg <= 1'b0;
                                    dbz_reg    <= 1'b1;
                                end else begin
                                    state_reg  <= DIV;
                                    cnt_reg    <= 5'd31;
                                    opb_reg    <= mag_b[31:0];
                                    rem_reg    <= 33'd0;
                                    quo_reg    <= mag_a[31:0];
                                    neg_lo_reg <= sign_a ^ sign_b;
                                    neg_hi_reg <= sign_a;
                                    dbz_reg    <= 1'b0;
                                end
                            end
                            OP_MFHI: result_reg <= hi_reg;
                            OP_MFLO: result_reg <= lo_reg;
                            default: ;
                        endcase
                    end
                end
                MUL: begin
                    prod_reg <= mul_next;
                    cnt_reg  <= cnt_reg - 5'd1;
                    if (cnt_reg == 5'd0) begin
                        state_reg <= FIX;
                    end
                end
                DIV: begin
                    rem_reg <= div_ok ? div_diff[32:0] : div_shift;
                    quo_reg <= {quo_reg[30:0], div_ok};
                    cnt_reg <= cnt_reg - 5'd1;
                    if (cnt_reg == 5'd0) begin
                        state_reg <= FIX;
                    end
                end
                FIX: begin
                    hi_reg      <= fix_hi;
                    lo_reg      <= fix_lo;
                    done_reg    <= 1'b1;
                    dbz_out_reg <= dbz_reg;
                    busy_reg    <= 1'b0;
                    state_reg   <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign busy        = busy_reg;
    assign done        = done_reg;
    assign div_by_zero = dbz_out_reg;
    assign hi          = hi_reg;
    assign lo          = lo_reg;
    assign result      = result_reg;

    logic unused_bits;
    assign unused_bits = ^{alu_ctrl[5], mag_a[32], mag_b[32], rem_reg[32]};

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed cases plus random ops vs. an arithmetic model.
// Compile with MULDIV_SIGNED_EN defined to check the signed build.
`timescale 1ns/1ps
module tb_muldiv_unit;

    localparam logic [5:0] C_MULT = 6'b001000;
    localparam logic [5:0] C_DIV  = 6'b001010;
    localparam logic [5:0] C_MFHI = 6'b001111;
    localparam logic [5:0] C_MFLO = 6'b000001;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [5:0]  alu_ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] result;
    logic        div_by_zero;

    int checks = 0;
    int errors = 0;
    logic [31:0] model_hi = 32'd0;
    logic [31:0] model_lo = 32'd0;
    logic [31:0] model_result = 32'd0;

    muldiv_unit dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .alu_ctrl(alu_ctrl),
        .a(a),
        .b(b),
        .busy(busy),
        .done(done),
        .hi(hi),
        .lo(lo),
        .result(result),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, want);
        end
    endtask

    // Reference: HI/LO from plain 64-bit arithmetic on the operand values.
    function automatic void model(input logic [5:0] ctrl, input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] eh, output logic [31:0] el, output bit ez);
        longint sx;
        longint sy;
        longint p;
        longint q;
        longint r;
`ifdef MULDIV_SIGNED_EN
        sx = longint'($signed(x));
        sy = longint'($signed(y));
`else
        sx = longint'({32'd0, x});
        sy = longint'({32'd0, y});
`endif
        ez = 1'b0;
        if (ctrl[4:0] == C_MULT[4:0]) begin
            p  = sx * sy;
            eh = p[63:32];
            el = p[31:0];
        end else if (y == 32'd0) begin
            eh = x;
            el = 32'hFFFF_FFFF;
            ez = 1'b1;
        end else begin
            q  = sx / sy;
            r  = sx % sy;
            eh = r[31:0];
            el = q[31:0];
        end
    endfunction

    // Issue a mult/div at the current negedge, wait for completion, end on the done cycle.
    task automatic run_op(input logic [5:0] ctrl, input logic [31:0] x, input logic [31:0] y, input bit inject);
        int n;
        bit early;
        logic [31:0] eh;
        logic [31:0] el;
        bit ez;
        model(ctrl, x, y, eh, el, ez);
        start = 1'b1;
        alu_ctrl = ctrl;
        a = x;
        b = y;
        @(negedge clk);
        start = 1'b0;
        a = $urandom;
        b = $urandom;
        chk("done_low_after_accept", done, 1'b0);
        n = 0;
        early = 1'b0;
        while (busy === 1'b1 && n < 200) begin
            if (done !== 1'b0) early = 1'b1;
            n++;
            if (inject && n == 5) begin
                start = 1'b1;
                alu_ctrl = C_DIV;
            end
            if (inject && n == 6) alu_ctrl = C_MFHI;
            if (inject && n == 7) start = 1'b0;
            @(negedge clk);
        end
        chk("busy_cycles", n, ez ? 32'd1 : 32'd33);
        chk("no_early_done", early, 1'b0);
        chk("done_pulse", done, 1'b1);
        chk("div_by_zero", div_by_zero, ez);
        chk("hi", hi, eh);
        chk("lo", lo, el);
        chk("result_hold", result, model_result);
        model_hi = eh;
        model_lo = el;
        $display("op=%02h a=%h b=%h -> hi=%h lo=%h dbz=%0b busy_cycles=%0d", ctrl, x, y, hi, lo, div_by_zero, n);
    endtask

    task automatic mf_read(input logic [5:0] ctrl);
        logic [31:0] want;
        want = (ctrl[4:0] == C_MFHI[4:0]) ? model_hi : model_lo;
        start = 1'b1;
        alu_ctrl = ctrl;
        a = $urandom;
        b = $urandom;
        @(negedge clk);
        start = 1'b0;
        model_result = want;
        chk("mf_result", result, want);
        chk("mf_busy", busy, 1'b0);
        chk("mf_done", done, 1'b0);
        $display("op=%02h -> result=%h", ctrl, result);
    endtask

    task automatic ignored_op(input logic [5:0] ctrl);
        start = 1'b1;
        alu_ctrl = ctrl;
        a = $urandom;
        b = $urandom;
        @(negedge clk);
        start = 1'b0;
        chk("ign_busy", busy, 1'b0);
        chk("ign_result", result, model_result);
        chk("ign_hi", hi, model_hi);
        chk("ign_lo", lo, model_lo);
        $display("op=%02h ignored -> busy=%0b result=%h", ctrl, busy, result);
    endtask

    initial begin
        logic [31:0] x;
        logic [31:0] y;
        rst_n = 1'b1;
        start = 1'b0;
        alu_ctrl = 6'd0;
        a = 32'd0;
        b = 32'd0;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_dbz", div_by_zero, 1'b0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_result", result, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Accepted on the first edge after reset release.
        run_op(C_MULT, 32'hFFFF_FFFD, 32'd7, 1'b0);
        mf_read(C_MFLO);
        mf_read(C_MFHI);
        run_op(C_DIV, 32'hFFFF_FFEF, 32'd5, 1'b0);
        mf_read(C_MFLO);
        run_op(C_DIV, 32'd17, 32'd5, 1'b0);
        mf_read(C_MFHI);
        run_op(C_DIV, 32'h1234_5678, 32'd0, 1'b0);
        run_op(C_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        // Back-to-back: next start is issued in the done cycle.
        run_op(C_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_op(C_DIV, 32'hDEAD_BEEF, 32'h0000_1234, 1'b0);
        mf_read(C_MFHI);
        ignored_op(6'b000000);
        ignored_op(6'b001001);
        mf_read(6'b100001);
        // Div and mfhi requests during a busy mult must be ignored.
        run_op(C_MULT, 32'h0001_0003, 32'h7FFF_0005, 1'b1);

        // Asynchronous reset mid-multiply.
        start = 1'b1;
        alu_ctrl = C_MULT;
        a = 32'h0000_1234;
        b = 32'h00AB_CDEF;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        chk("pre_reset_busy", busy, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        model_hi = 32'd0;
        model_lo = 32'd0;
        model_result = 32'd0;
        chk("arst_busy", busy, 1'b0);
        chk("arst_done", done, 1'b0);
        chk("arst_hi", hi, model_hi);
        chk("arst_lo", lo, model_lo);
        chk("arst_result", result, model_result);
        @(negedge clk);
        chk("arst_no_done", done, 1'b0);
        rst_n = 1'b1;
        run_op(C_MULT, 32'h0000_0010, 32'h0000_0020, 1'b0);

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 4))
                0: x = 32'h8000_0000;
                1: x = $urandom_range(0, 100);
                default: x = $urandom;
            endcase
            case ($urandom_range(0, 7))
                0: y = 32'd0;
                1: y = 32'd1;
                2: y = 32'hFFFF_FFFF;
                3: y = $urandom_range(1, 20);
                default: y = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0, 1: run_op({1'($urandom_range(0, 1)), C_MULT[4:0]}, x, y, 1'b0);
                2, 3: run_op({1'($urandom_range(0, 1)), C_DIV[4:0]}, x, y, 1'b0);
                4: mf_read(C_MFHI);
                default: mf_read(C_MFLO);
            endcase
        end
        @(negedge clk);
        chk("final_done_low", done, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
